// File: rtl/step_sequencer_pkg.sv
// Shared definitions for the step sequencer: FSM state encoding, stage index width
// and the stage one-hot decode.
package step_seq_pkg;

    localparam int IDX_W     = 3;
    localparam int MAX_STAGE = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LAUNCH    = 3'd1,
        WAIT_DONE = 3'd2,
        WAIT_TICK = 3'd3,
        HALT      = 3'd4
    } state_t;

    function automatic logic [MAX_STAGE-1:0] stage_onehot(input logic [IDX_W-1:0] idx);
        logic [MAX_STAGE-1:0] v;
        v      = {MAX_STAGE{1'b0}};
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/step_sequencer_timer.sv
// Step period counter: counts 0..STEP_CYCLES-1 while enabled and flags the last
// cycle of each period; holds its value while disabled.
module step_period_timer #(
    parameter int STEP_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);
    localparam int CW = $clog2(STEP_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(STEP_CYCLES - 1);

    logic [CW-1:0] count;

    // Period counter with wrap at the end of each step
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= {CW{1'b0}};
        end else if (en) begin
            if (count == LAST) begin
                count <= {CW{1'b0}};
            end else begin
                count <= count + CW'(1);
            end
        end
    end

    assign tick = en && (count == LAST);

endmodule

// File: rtl/step_sequencer.sv
// Per-time-step controller: launches N_STAGE compute stages in order once per
// step period, flags period overruns and halts on a stage that never finishes.
module step_sequencer
    import step_seq_pkg::*;
#(
    parameter int N_STAGE     = 4,
    parameter int STEP_CYCLES = 1000,
    parameter int TIMEOUT     = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_user,
    input  logic               stop_user,
    input  logic [N_STAGE-1:0] stage_done,
    output logic [N_STAGE-1:0] stage_sta,
    output logic               step_done,
    output logic [31:0]        step_count,
    output logic               busy,
    output logic               overrun,
    output logic               timeout_err,
    output logic [2:0]         err_stage
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]    T_LAST   = TW'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_STAGE - 1);

    state_t             state, state_nx;
    logic [IDX_W-1:0]   idx, idx_nx;
    logic [TW-1:0]      tcnt;
    logic [N_STAGE-1:0] sel;
    logic               stop_pending;
    logic               tick;
    logic               in_step;
    logic               start_evt;
    logic               done_hit;
    logic               complete;
    logic               expired;

    assign sel       = N_STAGE'(stage_onehot(idx));
    assign busy      = (state != IDLE) && (state != HALT);
    assign in_step   = (state == LAUNCH) || (state == WAIT_DONE);
    assign start_evt = !busy && start_user;
    // Only the bit of the stage being waited on counts; done beats timeout.
    assign done_hit  = (state == WAIT_DONE) && ((stage_done & sel) != {N_STAGE{1'b0}});
    assign complete  = done_hit && (idx == IDX_LAST);
    assign expired   = (state == WAIT_DONE) && !done_hit && (tcnt == T_LAST);
    assign stage_sta = (state == LAUNCH) ? sel : {N_STAGE{1'b0}};

    step_period_timer #(
        .STEP_CYCLES(STEP_CYCLES)
    ) u_timer (
        .clk (clk),
        .rst (rst),
        .clr (start_evt),
        .en  (busy),
        .tick(tick)
    );

    // Next-state and stage index selection
    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        case (state)
            IDLE, HALT: begin
                if (start_user) begin
                    state_nx = LAUNCH;
                    idx_nx   = {IDX_W{1'b0}};
                end else begin
                    state_nx = state;
                end
            end
            LAUNCH: begin
                state_nx = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (complete) begin
                    state_nx = WAIT_TICK;
                    idx_nx   = {IDX_W{1'b0}};
                end else if (done_hit) begin
                    state_nx = LAUNCH;
                    idx_nx   = idx + IDX_W'(1);
                end else if (expired) begin
                    state_nx = HALT;
                end else begin
                    state_nx = WAIT_DONE;
                end
            end
            WAIT_TICK: begin
                if (tick) begin
                    state_nx = stop_pending ? IDLE : LAUNCH;
                end else begin
                    state_nx = WAIT_TICK;
                end
            end
            default: begin
                state_nx = IDLE;
                idx_nx   = {IDX_W{1'b0}};
            end
        endcase
    end

    // State, timeout counter and sticky status registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            idx          <= {IDX_W{1'b0}};
            tcnt         <= {TW{1'b0}};
            stop_pending <= 1'b0;
            step_done    <= 1'b0;
            step_count   <= 32'd0;
            overrun      <= 1'b0;
            timeout_err  <= 1'b0;
            err_stage    <= 3'd0;
        end else begin
            state     <= state_nx;
            idx       <= idx_nx;
            step_done <= complete;
            if (state == LAUNCH) begin
                tcnt <= {TW{1'b0}};
            end else if (state == WAIT_DONE) begin
                tcnt <= tcnt + TW'(1);
            end
            if (start_evt) begin
                stop_pending <= 1'b0;
                step_count   <= 32'd0;
                overrun      <= 1'b0;
                timeout_err  <= 1'b0;
                err_stage    <= 3'd0;
            end else begin
                if (complete) begin
                    step_count <= step_count + 32'd1;
                end
                // A tick before the step finished is dropped; stepping carries on.
                if (tick && in_step) begin
                    overrun <= 1'b1;
                end
                if (expired) begin
                    timeout_err <= 1'b1;
                    err_stage   <= idx;
                end
                if (busy && stop_user) begin
                    stop_pending <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_step_sequencer.sv
// Scoreboard bench for step_sequencer: a transaction-level model predicts every
// stage launch and step completion from stage latencies and the step period grid.
module tb_step_sequencer;
    localparam int NS   = 3;
    localparam int SC   = 40;
    localparam int TO   = 20;
    localparam int MAXS = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_user;
    logic          stop_user;
    logic [NS-1:0] stage_done;
    logic [NS-1:0] stage_sta;
    logic          step_done;
    logic [31:0]   step_count;
    logic          busy;
    logic          overrun;
    logic          timeout_err;
    logic [2:0]    err_stage;

    always #5 clk = ~clk;

    step_sequencer #(.N_STAGE(NS), .STEP_CYCLES(SC), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .start_user(start_user), .stop_user(stop_user),
        .stage_done(stage_done), .stage_sta(stage_sta), .step_done(step_done),
        .step_count(step_count), .busy(busy), .overrun(overrun),
        .timeout_err(timeout_err), .err_stage(err_stage)
    );

    typedef struct {
        int            cyc;
        logic [NS-1:0] sta;
        logic          sd;
        logic [31:0]   cnt;
        logic          ov;
        logic          chk_ov;
    } ev_t;

    ev_t exp_q[$];
    ev_t mon_e;
    int  lat [MAXS][NS];
    int  due [NS];
    int  cyc = 0;
    int  vec = 0;
    int  err = 0;
    int  rstep, last;
    int  start_c, start2_c, stop_c, stop2_c, rst_c;
    bit  noise;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every launch or step completion must match the next predicted event
    always @(negedge clk) begin
        if (stage_sta != '0 || step_done) begin
            vec++;
            if (exp_q.size() == 0) begin
                err++;
                $display("FAIL event: got sta=%b step_done=%b cnt=%0d at cycle %0d, required no event",
                         stage_sta, step_done, step_count, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.cyc != cyc || mon_e.sta !== stage_sta || mon_e.sd !== step_done ||
                    mon_e.cnt !== step_count || (mon_e.chk_ov && mon_e.ov !== overrun)) begin
                    err++;
                    $display("FAIL event: got cycle %0d sta=%b sd=%b cnt=%0d ov=%b, required cycle %0d sta=%b sd=%b cnt=%0d ov=%b",
                             cyc, stage_sta, step_done, step_count, overrun,
                             mon_e.cyc, mon_e.sta, mon_e.sd, mon_e.cnt, mon_e.ov);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vec++;
        if (act !== req) begin
            err++;
            $display("FAIL %s: got %0d, required %0d at cycle %0d", name, act, req, cyc);
        end
    endtask

    // Period ticks fall at s-1+k*SC (k>=1) for stepping that first launched at s.
    function automatic int first_tick(input int s, input int a);
        int k;
        k = (a - s + SC) / SC;
        return s - 1 + k * SC;
    endfunction

    function automatic bit has_tick(input int s, input int a, input int b);
        return first_tick(s, a) <= b;
    endfunction

    function automatic void push_ev(input int c, input logic [NS-1:0] sta, input logic sd,
                                    input logic [31:0] cnt, input logic ov, input logic chk, input int rc);
        ev_t e;
        if (rc < 0 || c <= rc) begin
            e.cyc = c; e.sta = sta; e.sd = sd; e.cnt = cnt; e.ov = ov; e.chk_ov = chk;
            exp_q.push_back(e);
        end
    endfunction

    task automatic build_model(input int s, input int stc, input int rc, output int end_c,
                               output int cnt, output bit ov, output bit to, output int erri);
        int            launch, t, tk, step;
        bit            fin;
        logic [NS-1:0] one;
        launch = s; cnt = 0; ov = 0; to = 0; erri = 0; step = 0; fin = 0; end_c = s;
        while (!fin) begin
            t = launch;
            for (int i = 0; i < NS && !fin; i++) begin
                one = NS'(1) << i;
                push_ev(t, one, 1'b0, cnt, 1'b0, 1'b0, rc);
                if (lat[step % MAXS][i] > TO) begin
                    end_c = t + 1 + TO;
                    to = 1; erri = i; fin = 1;
                    if (has_tick(s, launch, end_c - 1)) ov = 1;
                end else begin
                    t = t + 1 + lat[step % MAXS][i];
                end
            end
            if (!fin) begin
                if (has_tick(s, launch, t - 1)) ov = 1;
                cnt++;
                push_ev(t, '0, 1'b1, cnt, ov, 1'b1, rc);
                tk = first_tick(s, t);
                if (stc >= s && stc < tk) begin
                    end_c = tk + 1; fin = 1;
                end else begin
                    launch = tk + 1; step++;
                end
            end
        end
    endtask

    // One clock: stage responders react to launches, then inputs for this cycle are driven.
    task automatic drive_cycle();
        logic [NS-1:0] d;
        @(posedge clk);
        #1;
        for (int i = 0; i < NS; i++) begin
            if (stage_sta[i]) begin
                if (i == 0) rstep++;
                due[i] = cyc + lat[((rstep > 0) ? rstep - 1 : 0) % MAXS][i];
                last = i;
            end
        end
        d = '0;
        for (int i = 0; i < NS; i++) if (due[i] == cyc) d[i] = 1'b1;
        if (noise) d = d | (NS'($urandom) & ~(NS'(1) << last));
        stage_done = d;
        start_user = (cyc == start_c) || (cyc == start2_c);
        stop_user  = (cyc == stop_c) || (cyc == stop2_c);
        rst        = (cyc < 4) || (cyc == rst_c);
    endtask

    task automatic set_lat(input int v);
        for (int k = 0; k < MAXS; k++) for (int i = 0; i < NS; i++) lat[k][i] = v;
    endtask

    function automatic int rand_lat();
        int r;
        r = int'($urandom_range(99, 0));
        if (r < 70)      return int'($urandom_range(11, 1));
        else if (r < 90) return int'($urandom_range(TO, 12));
        else if (r < 95) return TO;
        else             return int'($urandom_range(TO + 10, TO + 1));
    endfunction

    task automatic run_scenario(input int stop_off, input int rst_off, input bit nz, input bit ss);
        int s, end_c, cnt, erri, lim;
        bit ov, to;
        for (int i = 0; i < NS; i++) due[i] = -1;
        rstep = 0; last = 0; noise = nz;
        exp_q.delete();
        start_c = cyc + 2;
        s       = start_c + 1;
        stop_c  = (stop_off < 0) ? -1 : s + stop_off;
        rst_c   = (rst_off < 0) ? -1 : s + rst_off;
        stop2_c = ss ? start_c : -1;
        build_model(s, stop_c, rst_c, end_c, cnt, ov, to, erri);
        start2_c = (rst_c < 0 && end_c - s > 2) ? s + int'($urandom_range(end_c - s - 1, 0)) : -1;
        lim = (rst_c >= 0) ? rst_c + 1 : end_c + 2;
        while (cyc < lim) begin
            drive_cycle();
            if (cyc == s) check("busy_running", busy, 1);
        end
        if (rst_c >= 0) begin
            check("rst_sta", stage_sta, 0);
            check("rst_step_done", step_done, 0);
            check("rst_count", step_count, 0);
            check("rst_busy", busy, 0);
            check("rst_overrun", overrun, 0);
            check("rst_timeout", timeout_err, 0);
            check("rst_err_stage", err_stage, 0);
        end else begin
            check("end_busy", busy, 0);
            check("end_count", step_count, cnt);
            check("end_overrun", overrun, ov);
            check("end_timeout", timeout_err, to);
            if (to) check("end_err_stage", err_stage, erri);
        end
        check("events_left", exp_q.size(), 0);
    endtask

    initial begin
        rst = 1'b1; start_user = 1'b0; stop_user = 1'b0; stage_done = '0;
        start_c = -1; start2_c = -1; stop_c = -1; stop2_c = -1; rst_c = -1;
        rstep = 0; last = 0; noise = 0;
        for (int i = 0; i < NS; i++) due[i] = -1;
        set_lat(11);
        while (cyc < 4) drive_cycle();
        check("reset_sta", stage_sta, 0);
        check("reset_step_done", step_done, 0);
        check("reset_count", step_count, 0);
        check("reset_busy", busy, 0);
        check("reset_overrun", overrun, 0);
        check("reset_timeout", timeout_err, 0);
        check("reset_err_stage", err_stage, 0);

        set_lat(11);                   run_scenario(100, -1, 1'b0, 1'b0);
        set_lat(11); lat[0][2] = TO;   run_scenario(90, -1, 1'b0, 1'b0);
        set_lat(11); lat[0][1] = 1000; run_scenario(-1, -1, 1'b0, 1'b0);
        set_lat(11);                   run_scenario(9, -1, 1'b0, 1'b0);
        set_lat(11);                   run_scenario(60, 5, 1'b0, 1'b0);
        set_lat(11);                   run_scenario(70, -1, 1'b1, 1'b1);

        for (int n = 0; n < 25; n++) begin
            for (int k = 0; k < MAXS; k++) for (int i = 0; i < NS; i++) lat[k][i] = rand_lat();
            run_scenario(int'($urandom_range(130, 0)), -1, 1'($urandom_range(1, 0)),
                         1'($urandom_range(1, 0)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
